// File: rtl/mips_instr_loader_pkg.sv
// mips_instr_loader_pkg
//   Shared definitions for the MIPS instruction loader and encoder:
//   FSM state encodings, op-class codes and the MIPS opcode/funct values
//   that the control unit decodes.
package mips_instr_loader_pkg;

  // Loader session FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Decoded op classes carried on in_op; codes 8-15 are illegal
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_SLT = 4'd4,
    OP_LW  = 4'd5,
    OP_SW  = 4'd6,
    OP_BEQ = 4'd7
  } op_class_t;

  // Primary opcodes
  localparam logic [5:0] OPC_R   = 6'h00;
  localparam logic [5:0] OPC_LW  = 6'h23;
  localparam logic [5:0] OPC_SW  = 6'h2B;
  localparam logic [5:0] OPC_BEQ = 6'h04;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Encoded MIPS NOP (sll $0,$0,0)
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

endpackage

// File: rtl/mips_instr_enc.sv
// mips_instr_enc
//   Purely combinational encoder: op class plus register/immediate fields
//   to a 32-bit MIPS instruction word. Op classes 8-15 encode as NOP.
// Ports
//   op    in  4   op class (see op_class_t)
//   rs    in  5   source register
//   rt    in  5   second source / destination for I-type
//   rd    in  5   destination for R-type (ignored for I-type)
//   imm   in  16  immediate (ignored for R-type)
//   word  out 32  encoded instruction
module mips_instr_enc
  import mips_instr_loader_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic [31:0] word
);

  always_comb begin
    word = INSTR_NOP;
    case (op)
      OP_ADD:  word = {OPC_R, rs, rt, rd, 5'd0, FN_ADD};
      OP_SUB:  word = {OPC_R, rs, rt, rd, 5'd0, FN_SUB};
      OP_AND:  word = {OPC_R, rs, rt, rd, 5'd0, FN_AND};
      OP_OR:   word = {OPC_R, rs, rt, rd, 5'd0, FN_OR};
      OP_SLT:  word = {OPC_R, rs, rt, rd, 5'd0, FN_SLT};
      OP_LW:   word = {OPC_LW, rs, rt, imm};
      OP_SW:   word = {OPC_SW, rs, rt, imm};
      OP_BEQ:  word = {OPC_BEQ, rs, rt, imm};
      default: word = INSTR_NOP;
    endcase
  end

endmodule

// File: rtl/mips_instr_loader.sv
// mips_instr_loader
//   Accepts decoded instruction field bundles over a valid/ready stream,
//   encodes each into a 32-bit MIPS word and writes it sequentially into
//   instruction memory starting at BASE_ADDR. A session starts on a start
//   pulse and ends on in_last or after writing the top imem address.
//   Optional build macro: ILLEGAL_OP_EN -- op classes 8-15 are accepted but
//   not written and raise the sticky 'illegal' output; without it they are
//   written as NOP.
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start                begin a session (honoured in IDLE/DONE only)
//   in_valid / in_ready  field bundle handshake (in_ready only in LOAD)
//   in_op, in_rs, in_rt, in_rd, in_imm, in_last   field bundle
//   imem_we, imem_addr, imem_wdata                registered imem write port
//   busy                 LOAD state or a write strobe in flight
//   done                 session complete (level)
//   count                words written this session
//   illegal              (ILLEGAL_OP_EN only) sticky illegal-op flag
module mips_instr_loader
  import mips_instr_loader_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
`ifdef ILLEGAL_OP_EN
  output logic              illegal,
`endif
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic [31:0]       enc_word;
  logic              accept;
  logic              write_req;
  logic              end_session;

  mips_instr_enc u_enc (
    .op   (in_op),
    .rs   (in_rs),
    .rt   (in_rt),
    .rd   (in_rd),
    .imm  (in_imm),
    .word (enc_word)
  );

  assign in_ready = (state_reg == ST_LOAD);
  assign accept   = in_valid & in_ready;

`ifdef ILLEGAL_OP_EN
  // Illegal op classes are consumed but never reach imem
  assign write_req = accept & ~in_op[3];
`else
  assign write_req = accept;
`endif

  // Writing the top address closes the session so the pointer never wraps
  assign end_session = accept & (in_last | (write_req & (ptr_reg == LAST_ADDR)));

  assign done = (state_reg == ST_DONE);
  // imem_we covers the final write that lands in the first DONE cycle
  assign busy = (state_reg == ST_LOAD) | imem_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      ptr_reg    <= BASE;
      imem_we    <= 1'b0;
      imem_addr  <= BASE;
      imem_wdata <= 32'h0;
      count      <= '0;
`ifdef ILLEGAL_OP_EN
      illegal    <= 1'b0;
`endif
    end else begin
      imem_we <= write_req;
      if (write_req) begin
        imem_addr  <= ptr_reg;
        imem_wdata <= enc_word;
        count      <= count + 1'b1;
        if (ptr_reg != LAST_ADDR) begin
          ptr_reg <= ptr_reg + 1'b1;
        end
      end
`ifdef ILLEGAL_OP_EN
      if (accept & in_op[3]) begin
        illegal <= 1'b1;
      end
`endif
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          // No transfers happen here, so these clears never race a write
          if (start) begin
            state_reg <= ST_LOAD;
            ptr_reg   <= BASE;
            count     <= '0;
`ifdef ILLEGAL_OP_EN
            illegal   <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (end_session) begin
            state_reg <= ST_DONE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_instr_loader.sv
// tb_mips_instr_loader
//   Table-driven bench for mips_instr_loader. Expected imem writes are
//   pushed to a scoreboard queue when a bundle is driven and popped when
//   the DUT strobes imem_we. A second instance with ADDR_W=2 exercises the
//   top-of-memory stop. Build with ILLEGAL_OP_EN defined to cover that mode.
module tb_mips_instr_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start_s;
  logic        in_valid, in_last;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;

  logic        in_ready, imem_we, busy, done;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [6:0]  count;

  logic        in_ready_s, imem_we_s, busy_s, done_s;
  logic [1:0]  imem_addr_s;
  logic [31:0] imem_wdata_s;
  logic [2:0]  count_s;

`ifdef ILLEGAL_OP_EN
  logic illegal, illegal_s;
`endif

  always #5 clk = ~clk;

  mips_instr_loader #(.ADDR_W(6), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done),
`ifdef ILLEGAL_OP_EN
    .illegal(illegal),
`endif
    .count(count)
  );

  mips_instr_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_last(in_last), .imem_we(imem_we_s), .imem_addr(imem_addr_s), .imem_wdata(imem_wdata_s),
    .busy(busy_s), .done(done_s),
`ifdef ILLEGAL_OP_EN
    .illegal(illegal_s),
`endif
    .count(count_s)
  );

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        last;
    int          gap;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  vec_t vt[10];
  wr_t  q[$];
  wr_t  qs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_addr = 0;
  int   exp_addr_s = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: one compare pair per imem write on either instance
  always @(negedge clk) begin
    wr_t e;
    if (imem_we === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got @%0d %h expected no write", imem_addr, imem_wdata);
      end else begin
        e = q.pop_front();
        $display("write  @%0d %h (exp @%0d %h)", imem_addr, imem_wdata, e.addr, e.data);
        chk("wr_addr", 32'(imem_addr), 32'(e.addr));
        chk("wr_data", imem_wdata, e.data);
      end
    end
    if (imem_we_s === 1'b1) begin
      if (qs.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write_s: got @%0d %h expected no write", imem_addr_s, imem_wdata_s);
      end else begin
        e = qs.pop_front();
        $display("write_s @%0d %h (exp @%0d %h)", imem_addr_s, imem_wdata_s, e.addr, e.data);
        chk("wr_addr_s", 32'(imem_addr_s), 32'(e.addr));
        chk("wr_data_s", imem_wdata_s, e.data);
      end
    end
  end

  // Called at posedge+1. Presents one bundle after 'gap' idle cycles and
  // waits up to max_wait cycles for it to be accepted.
  task automatic send(input bit sel, input vec_t v, input int max_wait, output bit accepted);
    logic rdy;
    wr_t  e;
    in_valid = 1'b0;
    repeat (v.gap) begin
      @(posedge clk);
      #1;
    end
    in_op = v.op; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd; in_imm = v.imm; in_last = v.last;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < max_wait; i++) begin
      rdy = sel ? in_ready_s : in_ready;
      if (rdy) begin
        e.data = v.word;
`ifdef ILLEGAL_OP_EN
        if (!v.op[3]) begin
`else
        begin
`endif
          if (sel) begin
            e.addr = 6'(exp_addr_s);
            exp_addr_s++;
            qs.push_back(e);
          end else begin
            e.addr = 6'(exp_addr);
            exp_addr++;
            q.push_back(e);
          end
        end
        @(posedge clk);
        #1;
        accepted = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    $display("send%s op=%0d rs=%0d rt=%0d rd=%0d imm=%h last=%0b accepted=%0b",
             sel ? "_s" : "", v.op, v.rs, v.rt, v.rd, v.imm, v.last, accepted);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start_s = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start_s = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   acc;
    int   nacc;
    vec_t v;

    //           op    rs     rt     rd     imm       last  gap word
    vt[0] = '{4'd0,  5'd1,  5'd2,  5'd3,  16'h0000, 1'b0, 0, 32'h00221820}; // add
    vt[1] = '{4'd5,  5'd4,  5'd5,  5'd0,  16'h0010, 1'b0, 1, 32'h8C850010}; // lw
    vt[2] = '{4'd7,  5'd1,  5'd2,  5'd0,  16'hFFFE, 1'b1, 0, 32'h1022FFFE}; // beq last
    vt[3] = '{4'd1,  5'd5,  5'd6,  5'd7,  16'h1234, 1'b0, 0, 32'h00A63822}; // sub
    vt[4] = '{4'd2,  5'd31, 5'd0,  5'd1,  16'h0000, 1'b0, 0, 32'h03E00824}; // and
    vt[5] = '{4'd3,  5'd0,  5'd31, 5'd31, 16'h0000, 1'b0, 2, 32'h001FF825}; // or
    vt[6] = '{4'd4,  5'd2,  5'd3,  5'd4,  16'hFFFF, 1'b0, 0, 32'h0043202A}; // slt
    vt[7] = '{4'd6,  5'd29, 5'd8,  5'd9,  16'h0004, 1'b0, 1, 32'hAFA80004}; // sw
    vt[8] = '{4'd12, 5'd7,  5'd7,  5'd7,  16'hABCD, 1'b0, 0, 32'h00000000}; // illegal
    vt[9] = '{4'd0,  5'd3,  5'd3,  5'd3,  16'h0000, 1'b1, 0, 32'h00631820}; // add last

    start = 1'b0; start_s = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_op = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_imm = 16'h0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Valid without start: nothing may be accepted or written
    in_op = vt[0].op; in_rs = vt[0].rs; in_rt = vt[0].rt; in_rd = vt[0].rd;
    in_valid = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("idle_ready", 32'(in_ready), 32'd0);
    chk("idle_count", 32'(count), 32'd0);
    in_valid = 1'b0;

    // Session 1: add, lw, beq(last)
    pulse_start(1'b0);
    exp_addr = 0;
    for (int k = 0; k < 3; k++) begin
      send(1'b0, vt[k], 8, acc);
      chk("s1_accept", 32'(acc), 32'd1);
    end
    // Final write lands in the first DONE cycle
    chk("s1_done_edge", 32'(done), 32'd1);
    chk("s1_we_edge", 32'(imem_we), 32'd1);
    chk("s1_busy_edge", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    chk("s1_busy_after", 32'(busy), 32'd0);
    chk("s1_count", 32'(count), 32'd3);
    chk("s1_ready", 32'(in_ready), 32'd0);

    // Session 2: gapped and back-to-back mix, includes an illegal op class
    pulse_start(1'b0);
    chk("s2_done_clr", 32'(done), 32'd0);
    chk("s2_count_clr", 32'(count), 32'd0);
    chk("s2_ready", 32'(in_ready), 32'd1);
    exp_addr = 0;
    for (int k = 3; k < 10; k++) begin
      send(1'b0, vt[k], 8, acc);
      chk("s2_accept", 32'(acc), 32'd1);
    end
    chk("s2_done", 32'(done), 32'd1);
    @(posedge clk);
    #1;
`ifdef ILLEGAL_OP_EN
    chk("s2_count", 32'(count), 32'd6);
    chk("s2_last_addr", 32'(imem_addr), 32'd5);
    chk("s2_illegal", 32'(illegal), 32'd1);
    pulse_start(1'b0);
    chk("s2_illegal_clr", 32'(illegal), 32'd0);
    // Illegal op with last still ends the session
    v = vt[8];
    v.last = 1'b1;
    send(1'b0, v, 8, acc);
    chk("ill_last_done", 32'(done), 32'd1);
    chk("ill_last_we", 32'(imem_we), 32'd0);
`else
    chk("s2_count", 32'(count), 32'd7);
    chk("s2_last_addr", 32'(imem_addr), 32'd6);
`endif

    // Small instance: 5 words, no last, only 4 fit
    pulse_start(1'b1);
    exp_addr_s = 0;
    nacc = 0;
    for (int k = 0; k < 5; k++) begin
      v = vt[3 + k];
      v.last = 1'b0;
      v.gap = k % 2;
      send(1'b1, v, 6, acc);
      if (acc) nacc++;
      if (k == 3) chk("small_done_4th", 32'(done_s), 32'd1);
    end
    chk("small_accepts", 32'(nacc), 32'd4);
    chk("small_count", 32'(count_s), 32'd4);
    chk("small_ready", 32'(in_ready_s), 32'd0);
    chk("small_addr", 32'(imem_addr_s), 32'd3);

    // Async reset right after an accept: the pending write is dropped
    pulse_start(1'b0);
    exp_addr = 0;
    send(1'b0, vt[0], 8, acc);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'd0);
    chk("mid_rst_wdata", imem_wdata, 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    pulse_start(1'b0);
    exp_addr = 0;
    v = vt[6];
    v.last = 1'b1;
    send(1'b0, v, 8, acc);
    @(posedge clk);
    #1;
    chk("restart_count", 32'(count), 32'd1);
    chk("restart_addr", 32'(imem_addr), 32'd0);
    chk("restart_done", 32'(done), 32'd1);

    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("q_empty", 32'(q.size()), 32'd0);
    chk("qs_empty", 32'(qs.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
